// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshake bundle for nibble_serial_adder.
// The slave side is the adder; the master side is the producer and consumer of results.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit ripple adder,
// processing one nibble per clock, least-significant nibble first.

module fulladder4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin : ripple
        logic c;
        c = cin;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             last_nib;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == IW'(k)) begin
                a_nib = a_r[4*k +: 4];
                b_nib = b_r[4*k +: 4];
            end
        end
    end

    assign last_nib = (idx == IW'(N - 1));

    fulladder4b u_fa (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (c_r),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // in_ready is held low during reset and rises on the first edge after release.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            c_r         <= 1'b0;
            idx         <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.a;
                        b_r        <= bus.sub ? ~bus.b : bus.b;
                        c_r        <= bus.cin ^ bus.sub;
                        sum_r      <= '0;
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (idx == IW'(k)) sum_r[4*k +: 4] <= nib_sum;
                    end
                    c_r <= nib_cout;
                    if (last_nib) begin
                        idx         <= '0;
                        carry_r     <= nib_cout;
                        // Overflow: operands share a sign that the result does not.
                        ovf_r       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                       (nib_sum[3] != a_r[WIDTH-1]);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.carry     = carry_r;
    assign bus.ovf       = ovf_r;
endmodule
